ppu_interrupt: RTL and testbench
================================

PPU_INTERRUPT -- requirements
Module: ppu_interrupt

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port: int_enabled_i  input  8  per-source interrupt enable mask.
REQ-004 SHALL have port: int_clear_all_i  input  1  synchronous pulse; clears all triggered flags.
REQ-005 SHALL have port: int_triggered_o  output  8  sticky per-source triggered flags.
REQ-006 SHALL have port: int_any_triggered_o  output  1  OR of int_triggered_o.
REQ-007 SHALL have port: burst_n  input  1  PPU colour-burst strobe, active-low, asynchronous to clock.
REQ-008 SHALL have port: csync_n  input  1  PPU composite sync, active-low, asynchronous.
REQ-009 SHALL have port: hblank  input  1  PPU horizontal blank, active-high, asynchronous.
REQ-010 SHALL have port: vblank  input  1  PPU vertical blank, active-high, asynchronous.
REQ-011 SHALL have parameter: none; source count fixed at 8.

Function
REQ-012 SHALL pass each of the 4 video inputs through a 2-flop synchronizer, then a third "previous" flop for edge detection.
REQ-013 SHALL map sources to bits:
- bit0 = burst_n falling; bit1 = burst_n rising
- bit2 = csync_n falling; bit3 = csync_n rising
- bit4 = hblank rising; bit5 = hblank falling
- bit6 = vblank rising; bit7 = vblank falling
REQ-014 SHALL set int_triggered_o[i] on the clock edge where edge event i is detected AND int_enabled_i[i] = 1 at that edge.
REQ-015 SHALL ignore events whose enable bit is 0; such events are not remembered and do not fire if enabled later.
REQ-016 SHALL keep a set flag set until int_clear_all_i or reset; clearing int_enabled_i[i] does not clear flag i.
REQ-017 SHALL clear all 8 flags on a rising edge where int_clear_all_i = 1.
REQ-018 SHALL give priority to set when int_clear_all_i and a new enabled event coincide on the same edge: that bit ends the cycle at 1, all other bits clear.
REQ-019 SHALL make int_any_triggered_o a combinational OR of the registered flags (no extra latency).
REQ-020 SHALL have latency: input change settled before rising edge E0 -> flag visible after edge E2.
REQ-021 SHALL detect at most one edge per input per clock; input pulses shorter than one clock period are not guaranteed to be seen.

Reset
REQ-022 SHALL, while reset = 0, force int_triggered_o = 8'h00 and int_any_triggered_o = 0.
REQ-023 SHALL reset synchronizer/previous flops to each input's inactive level (burst_n = 1, csync_n = 1, hblank = 0, vblank = 0), so no spurious edge fires after reset release when inputs sit idle.
REQ-024 SHALL, if reset asserts mid-operation, lose all pending flags and in-flight edges.

Structure
REQ-025 SHALL place bit-index constants (INT_BURST_FALL = 0 ... INT_VBLANK_FALL = 7) and the source count (8) in the shared PPU package.
REQ-026 SHALL use one sub-module, ppu_interrupt_edge (sync + rise/fall detect, reset-level parameter), instantiated 4 times.

Verification
REQ-027 SHALL pass: enables = 8'h00, pulse each of burst_n low, csync_n low, hblank high, vblank high for 3 clocks -> int_triggered_o stays 8'h00, any = 0.
REQ-028 SHALL pass: enables = 8'hFF, same pulses -> int_triggered_o = 8'hFF after the last edge, any = 1; bit0 rises exactly 2 edges after the burst_n falling sample.
REQ-029 SHALL pass: one-clock int_clear_all_i pulse -> int_triggered_o = 8'h00 and any = 0 on the next edge; idle inputs do not re-trigger.
REQ-030 SHALL pass: enables = 8'h50, hblank and vblank high-pulses -> int_triggered_o = 8'h50.
REQ-031 SHALL pass: clear pulse coincident with a detected vblank rising edge (enabled) -> int_triggered_o = 8'h40.
REQ-032 SHALL pass: reset released with idle inputs -> no flag sets; reset asserted with flags = 8'hFF -> 8'h00 immediately (asynchronous).

Source files
------------

// File: rtl/ppu_interrupt_pkg.sv
// rtl/ppu_interrupt_pkg.sv - shared PPU interrupt constants and flag-merge helper
package ppu_interrupt_pkg;

   localparam int INT_SOURCE_COUNT = 8;

   localparam int INT_BURST_FALL   = 0;
   localparam int INT_BURST_RISE   = 1;
   localparam int INT_CSYNC_FALL   = 2;
   localparam int INT_CSYNC_RISE   = 3;
   localparam int INT_HBLANK_RISE  = 4;
   localparam int INT_HBLANK_FALL  = 5;
   localparam int INT_VBLANK_RISE  = 6;
   localparam int INT_VBLANK_FALL  = 7;

   typedef logic [INT_SOURCE_COUNT-1:0] int_mask_t;

   // A clear that coincides with a new hit keeps only the new hit.
   function automatic int_mask_t merge_flags(input int_mask_t flags,
                                             input int_mask_t hits,
                                             input logic      clear_all);
      return clear_all ? hits : (flags | hits);
   endfunction

endpackage

// File: rtl/ppu_interrupt_edge.sv
// rtl/ppu_interrupt_edge.sv - 2-flop synchronizer plus previous flop with rise/fall detect
module ppu_interrupt_edge #(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic sync_q1;
   logic sync_q2;
   logic prev_q;

   // Reset to the idle level so a quiet input never looks like an edge at release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q1 <= RESET_LEVEL;
         sync_q2 <= RESET_LEVEL;
         prev_q  <= RESET_LEVEL;
      end else begin
         sync_q1 <= async_in;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
      end
   end

   assign rise =  sync_q2 & ~prev_q;
   assign fall = ~sync_q2 &  prev_q;

endmodule

// File: rtl/ppu_interrupt.sv
// rtl/ppu_interrupt.sv - sticky edge-triggered interrupt flags for PPU video timing strobes
module ppu_interrupt
   import ppu_interrupt_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] int_enabled_i,
   input  logic       int_clear_all_i,
   output logic [7:0] int_triggered_o,
   output logic       int_any_triggered_o,
   input  logic       burst_n,
   input  logic       csync_n,
   input  logic       hblank,
   input  logic       vblank
);

   logic burst_rise, burst_fall;
   logic csync_rise, csync_fall;
   logic hblank_rise, hblank_fall;
   logic vblank_rise, vblank_fall;

   int_mask_t events;
   int_mask_t hits;
   int_mask_t flags_q;

   ppu_interrupt_edge #(.RESET_LEVEL(1'b1)) u_burst (
      .clock    (clock),
      .reset    (reset),
      .async_in (burst_n),
      .rise     (burst_rise),
      .fall     (burst_fall)
   );

   ppu_interrupt_edge #(.RESET_LEVEL(1'b1)) u_csync (
      .clock    (clock),
      .reset    (reset),
      .async_in (csync_n),
      .rise     (csync_rise),
      .fall     (csync_fall)
   );

   ppu_interrupt_edge #(.RESET_LEVEL(1'b0)) u_hblank (
      .clock    (clock),
      .reset    (reset),
      .async_in (hblank),
      .rise     (hblank_rise),
      .fall     (hblank_fall)
   );

   ppu_interrupt_edge #(.RESET_LEVEL(1'b0)) u_vblank (
      .clock    (clock),
      .reset    (reset),
      .async_in (vblank),
      .rise     (vblank_rise),
      .fall     (vblank_fall)
   );

   always_comb begin
      events                  = '0;
      events[INT_BURST_FALL]  = burst_fall;
      events[INT_BURST_RISE]  = burst_rise;
      events[INT_CSYNC_FALL]  = csync_fall;
      events[INT_CSYNC_RISE]  = csync_rise;
      events[INT_HBLANK_RISE] = hblank_rise;
      events[INT_HBLANK_FALL] = hblank_fall;
      events[INT_VBLANK_RISE] = vblank_rise;
      events[INT_VBLANK_FALL] = vblank_fall;
   end

   // Disabled events are dropped here, so enabling later cannot replay them.
   assign hits = events & int_enabled_i;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= merge_flags(flags_q, hits, int_clear_all_i);
      end
   end

   assign int_triggered_o     = flags_q;
   assign int_any_triggered_o = |flags_q;

endmodule

// File: tb/tb_ppu_interrupt.sv
// tb/tb_ppu_interrupt.sv - directed and randomized self-checking bench for ppu_interrupt
module tb_ppu_interrupt;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] int_enabled_i = 8'h00;
   logic       int_clear_all_i = 1'b0;
   logic       burst_n = 1'b1;
   logic       csync_n = 1'b1;
   logic       hblank = 1'b0;
   logic       vblank = 1'b0;
   logic [7:0] int_triggered_o;
   logic       int_any_triggered_o;

   int errors = 0;
   int checks = 0;

   // Reference state: flags plus the input value seen at each recent clock edge,
   // packed as {vblank, hblank, csync_n, burst_n}.
   localparam logic [3:0] IDLE = 4'b0011;
   logic [7:0] m_flags = 8'h00;
   logic [3:0] samples[$];

   ppu_interrupt dut (
      .clock               (clock),
      .reset               (reset),
      .int_enabled_i       (int_enabled_i),
      .int_clear_all_i     (int_clear_all_i),
      .int_triggered_o     (int_triggered_o),
      .int_any_triggered_o (int_any_triggered_o),
      .burst_n             (burst_n),
      .csync_n             (csync_n),
      .hblank              (hblank),
      .vblank              (vblank)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] edge_events(input logic [3:0] was, input logic [3:0] now);
      logic [7:0] ev;
      ev[0] =  was[0] && !now[0];
      ev[1] = !was[0] &&  now[0];
      ev[2] =  was[1] && !now[1];
      ev[3] = !was[1] &&  now[1];
      ev[4] = !was[2] &&  now[2];
      ev[5] =  was[2] && !now[2];
      ev[6] = !was[3] &&  now[3];
      ev[7] =  was[3] && !now[3];
      return ev;
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_flags = 8'h00;
      samples = {IDLE, IDLE, IDLE};
   endtask

   // An input sampled at edge k is reported at edge k+2 against its value at edge k-1.
   task automatic tick();
      logic [7:0] hit;
      @(posedge clock);
      if (!reset) begin
         model_reset();
      end else begin
         samples.push_back({vblank, hblank, csync_n, burst_n});
         hit = edge_events(samples[0], samples[1]) & int_enabled_i;
         m_flags = int_clear_all_i ? hit : (m_flags | hit);
         void'(samples.pop_front());
      end
      #1;
      check("flags_model", int_triggered_o, m_flags);
      check("any_model", {7'b0, int_any_triggered_o}, {7'b0, |m_flags});
   endtask

   task automatic drive_source(input int which, input logic active);
      case (which)
         0: burst_n = !active;
         1: csync_n = !active;
         2: hblank  =  active;
         default: vblank = active;
      endcase
   endtask

   task automatic pulse(input int which);
      drive_source(which, 1'b1);
      repeat (3) tick();
      drive_source(which, 1'b0);
      repeat (4) tick();
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      check("in_reset_flags", int_triggered_o, 8'h00);
      check("in_reset_any", {7'b0, int_any_triggered_o}, 8'h00);

      reset = 1'b1;
      repeat (6) tick();
      check("idle_release", int_triggered_o, 8'h00);

      int_enabled_i = 8'h00;
      for (int s = 0; s < 4; s++) pulse(s);
      check("disabled_pulses", int_triggered_o, 8'h00);
      check("disabled_any", {7'b0, int_any_triggered_o}, 8'h00);

      int_enabled_i = 8'hFF;
      burst_n = 1'b0;
      tick();
      check("burst_fall_e0", {7'b0, int_triggered_o[0]}, 8'h00);
      tick();
      check("burst_fall_e1", {7'b0, int_triggered_o[0]}, 8'h00);
      tick();
      check("burst_fall_e2", {7'b0, int_triggered_o[0]}, 8'h01);
      burst_n = 1'b1;
      repeat (4) tick();
      for (int s = 1; s < 4; s++) pulse(s);
      check("all_enabled", int_triggered_o, 8'hFF);
      check("all_enabled_any", {7'b0, int_any_triggered_o}, 8'h01);

      int_clear_all_i = 1'b1;
      tick();
      int_clear_all_i = 1'b0;
      check("clear_flags", int_triggered_o, 8'h00);
      check("clear_any", {7'b0, int_any_triggered_o}, 8'h00);
      repeat (5) tick();
      check("clear_no_retrigger", int_triggered_o, 8'h00);

      int_enabled_i = 8'h50;
      pulse(2);
      pulse(3);
      check("mask_50", int_triggered_o, 8'h50);

      int_enabled_i = 8'hFF;
      vblank = 1'b1;
      repeat (2) tick();
      int_clear_all_i = 1'b1;
      tick();
      int_clear_all_i = 1'b0;
      check("clear_vs_set", int_triggered_o, 8'h40);
      int_enabled_i = 8'h00;
      vblank = 1'b0;
      repeat (4) tick();
      check("disable_keeps_flag", int_triggered_o, 8'h40);

      int_enabled_i = 8'hFF;
      for (int s = 0; s < 4; s++) pulse(s);
      check("refill_ff", int_triggered_o, 8'hFF);
      reset = 1'b0;
      model_reset();
      #1;
      check("async_reset", int_triggered_o, 8'h00);
      check("async_reset_any", {7'b0, int_any_triggered_o}, 8'h00);
      tick();
      reset = 1'b1;
      repeat (4) tick();

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) burst_n = ~burst_n;
         if ($urandom_range(0, 3) == 0) csync_n = ~csync_n;
         if ($urandom_range(0, 4) == 0) hblank  = ~hblank;
         if ($urandom_range(0, 6) == 0) vblank  = ~vblank;
         if ($urandom_range(0, 15) == 0) int_enabled_i = 8'($urandom);
         int_clear_all_i = ($urandom_range(0, 11) == 0);
         if (reset && $urandom_range(0, 149) == 0) begin
            reset = 1'b0;
            model_reset();
            #1;
            check("rand_async_reset", int_triggered_o, 8'h00);
         end else begin
            reset = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
